// File: rtl/button_pkg.sv
// Shared constants for the pet-control button conditioner: channel indices,
// channel count and default timing at 50 MHz.
package button_pkg;

    localparam int NUM_BTN = 6;

    localparam int BTN_FEED   = 0;
    localparam int BTN_LIGHT  = 1;
    localparam int BTN_ECHO   = 2;
    localparam int BTN_HEAL   = 3;
    localparam int BTN_CHANGE = 4;
    localparam int BTN_TEST   = 5;

    localparam int DEFAULT_DEBOUNCE_CYC = 1_000_000;
    localparam int DEFAULT_HOLD_CYC     = 250_000_000;

    // Keeps only the lowest set bit, so feed beats every other command.
    function automatic logic [NUM_BTN-1:0] lowest_one(input logic [NUM_BTN-1:0] v);
        logic [NUM_BTN-1:0] r;
        r = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, symmetric debounce counter and
// press-edge detector on the accepted level.
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic rise
);

    localparam int             CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;
    logic          pressed;

    assign pressed = ~s2;

    // Synchroniser flops reset to the released level so a held button is
    // seen as a fresh press once reset drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            db   <= 1'b0;
            db_d <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= btn_n;
            s2   <= s1;
            db_d <= db;
            if (pressed != db) begin
                if (cnt == CNT_MAX) begin
                    db  <= pressed;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = db;
    assign rise  = db & ~db_d;

endmodule

// File: rtl/button_conditioner.sv
// Turns six raw active-low buttons into one-hot single-cycle command pulses;
// TEST fires only after a long continuous hold.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEFAULT_HOLD_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic               feeding,
    output logic               light_out,
    output logic               echo_sig,
    output logic               healing,
    output logic               change_state,
    output logic               test,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int             HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYC - 1);
    localparam logic [NUM_BTN-1:0] TEST_MASK = NUM_BTN'(1) << BTN_TEST;

    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] raw_pulse;
    logic [NUM_BTN-1:0] pulse_q;
    logic [HW-1:0]      hold_cnt;
    logic               hold_fired;
    logic               raw_test;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[i]),
            .level (db[i]),
            .rise  (rise[i])
        );
    end

    assign raw_test = db[BTN_TEST] && (hold_cnt == HOLD_MAX) && !hold_fired;

    // Hold timer saturates at its terminal count; hold_fired blocks any
    // repeat until the button is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            hold_fired <= 1'b0;
        end else if (!db[BTN_TEST]) begin
            hold_cnt   <= '0;
            hold_fired <= 1'b0;
        end else begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (raw_test) begin
                hold_fired <= 1'b1;
            end
        end
    end

    // The TEST press edge is discarded; that channel only fires from the hold timer.
    assign raw_pulse = (rise & ~TEST_MASK) | (raw_test ? TEST_MASK : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= lowest_one(raw_pulse);
        end
    end

    assign feeding      = pulse_q[BTN_FEED];
    assign light_out    = pulse_q[BTN_LIGHT];
    assign echo_sig     = pulse_q[BTN_ECHO];
    assign healing      = pulse_q[BTN_HEAL];
    assign change_state = pulse_q[BTN_CHANGE];
    assign test         = pulse_q[BTN_TEST];
    assign btn_level    = db;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold timing:
// latency, glitch rejection, bounce, long-press TEST, priority and reset.
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [5:0] btn_n;
    logic       feeding;
    logic       light_out;
    logic       echo_sig;
    logic       healing;
    logic       change_state;
    logic       test;
    logic [5:0] btn_level;
    logic [5:0] pulses;

    int vectors;
    int miscompares;
    int cyc;
    int pulse_cnt [6];
    int first_at  [6];
    logic [5:0] level_seen;

    button_conditioner #(
        .DEBOUNCE_CYC (4),
        .HOLD_CYC     (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .feeding      (feeding),
        .light_out    (light_out),
        .echo_sig     (echo_sig),
        .healing      (healing),
        .change_state (change_state),
        .test         (test),
        .btn_level    (btn_level)
    );

    assign pulses = {test, change_state, healing, echo_sig, light_out, feeding};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        cyc        = 0;
        level_seen = '0;
        for (int i = 0; i < 6; i++) begin
            pulse_cnt[i] = 0;
            first_at[i]  = -1;
        end
    endtask

    // Drive a pattern, then step the clock, sampling 1 time unit after each edge.
    task automatic applyStimulus(input logic [5:0] pattern, input int cycles);
        btn_n = pattern;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            level_seen = level_seen | btn_level;
            for (int i = 0; i < 6; i++) begin
                if (pulses[i] === 1'b1) begin
                    pulse_cnt[i]++;
                    if (first_at[i] < 0) first_at[i] = cyc;
                end
            end
            if (!rst) checkOutput("onehot", int'($countones(pulses) <= 1), 1);
        end
    endtask

    initial begin
        logic [5:0] pat;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clearCounts();
        applyStimulus(6'b111111, 2);
        checkOutput("reset_no_x", int'($isunknown({pulses, btn_level})), 0);
        checkOutput("reset_pulses", int'(pulses), 0);
        checkOutput("reset_level", int'(btn_level), 0);
        #1 rst = 1'b0;

        // Feed: held press
        clearCounts();
        applyStimulus(6'b111110, 30);
        checkOutput("feed_count", pulse_cnt[0], 1);
        checkOutput("feed_latency", first_at[0], 7);
        checkOutput("feed_level", int'(btn_level[0]), 1);
        checkOutput("feed_others", pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5], 0);
        clearCounts();
        applyStimulus(6'b111111, 12);
        checkOutput("feed_release_pulse", pulse_cnt[0], 0);
        checkOutput("feed_release_level", int'(btn_level[0]), 0);

        // Echo: 3-cycle glitch
        clearCounts();
        applyStimulus(6'b111011, 3);
        applyStimulus(6'b111111, 12);
        checkOutput("echo_glitch_pulse", pulse_cnt[2], 0);
        checkOutput("echo_glitch_level", int'(level_seen[2]), 0);

        // Heal: bounce then hold, then bounce on release
        clearCounts();
        for (int i = 0; i < 10; i++) begin
            pat    = 6'b111111;
            pat[3] = (i % 2 == 1);
            applyStimulus(pat, 1);
        end
        checkOutput("heal_bounce_pulse", pulse_cnt[3], 0);
        clearCounts();
        applyStimulus(6'b110111, 20);
        checkOutput("heal_count", pulse_cnt[3], 1);
        checkOutput("heal_latency", first_at[3], 7);
        clearCounts();
        for (int i = 0; i < 10; i++) begin
            pat    = 6'b111111;
            pat[3] = (i % 2 == 0);
            applyStimulus(pat, 1);
        end
        applyStimulus(6'b111111, 12);
        checkOutput("heal_release_pulse", pulse_cnt[3], 0);
        checkOutput("heal_release_level", int'(btn_level[3]), 0);

        // Test: short press, then long hold
        clearCounts();
        applyStimulus(6'b011111, 10);
        applyStimulus(6'b111111, 10);
        checkOutput("test_short_pulse", pulse_cnt[5], 0);
        checkOutput("test_short_level", int'(level_seen[5]), 1);
        clearCounts();
        applyStimulus(6'b011111, 60);
        checkOutput("test_long_count", pulse_cnt[5], 1);
        checkOutput("test_long_at", first_at[5], 26);
        checkOutput("test_long_level", int'(btn_level[5]), 1);
        applyStimulus(6'b111111, 15);
        checkOutput("test_release_count", pulse_cnt[5], 1);

        // Light + change on the same edge
        clearCounts();
        applyStimulus(6'b101101, 20);
        checkOutput("prio_light_count", pulse_cnt[1], 1);
        checkOutput("prio_light_latency", first_at[1], 7);
        checkOutput("prio_levels", int'(level_seen & 6'b010010), 18);
        applyStimulus(6'b111111, 12);
        checkOutput("prio_change_count", pulse_cnt[4], 0);

        // Reset mid-debounce while feed is held
        clearCounts();
        applyStimulus(6'b111110, 3);
        checkOutput("rst_pre_pulse", pulse_cnt[0], 0);
        rst = 1'b1;
        applyStimulus(6'b111110, 1);
        checkOutput("rst_out_1", int'({pulses, btn_level}), 0);
        applyStimulus(6'b111110, 1);
        checkOutput("rst_out_2", int'({pulses, btn_level}), 0);
        rst = 1'b0;
        clearCounts();
        applyStimulus(6'b111110, 15);
        checkOutput("rst_feed_count", pulse_cnt[0], 1);
        checkOutput("rst_feed_latency", first_at[0], 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the six raw active-low pet-control buttons into clean, active-high, single-cycle command pulses for the pet-status FSM. The block sits between the board push-buttons and the status FSM.
Processing per channel: two-flop synchroniser, then debounce, then press-edge detection.
The TEST button is a long-press: it yields a pulse only after a continuous hold.
A priority stage keeps the command pulses one-hot, because the FSM does not arbitrate simultaneous commands.

Parameters:
DEBOUNCE_CYC, 1_000_000, cycles a synchronised level must be stable before it is accepted (20 ms at 50 MHz).
HOLD_CYC, 250_000_000, cycles the debounced TEST level must stay pressed before test_pulse fires (5 s at 50 MHz).

Ports:
clk  in  1  system clock, 50 MHz.
rst  in  1  synchronous, active-high reset.
btn_n  in  6  raw buttons, active-low, asynchronous. Bit order: [0] feed, [1] light_out, [2] echo, [3] heal, [4] change_state, [5] test.
feeding  out  1  one-cycle pulse, feed command.
light_out  out  1  one-cycle pulse, sleep command.
echo_sig  out  1  one-cycle pulse, play command.
healing  out  1  one-cycle pulse, heal command.
change_state  out  1  one-cycle pulse, select next stat in test mode.
test  out  1  one-cycle pulse, toggle test mode (long press only).
btn_level  out  6  debounced pressed levels, active-high, for display and debug.

Behaviour:
- Reset values (all synchronous on rst=1):
  - Synchroniser flops = 1 (released).
  - Debounced levels = 0.
  - Debounce and hold counters = 0.
  - All pulse outputs = 0; btn_level = 0.
  - hold_fired = 0.
- Synchroniser: s1 <= btn_n; s2 <= s1. The pressed sample is ~s2.
- Debounce, per channel:
  - If ~s2 != db: cnt <= cnt+1. When cnt == DEBOUNCE_CYC-1, db <= ~s2 and cnt <= 0.
  - If ~s2 == db: cnt <= 0.
  - Counter width is clog2(DEBOUNCE_CYC).
  - Press and release are debounced symmetrically.
- Edge detection: raw_pulse[i] = db[i] & ~db_d[i], with db_d registered. Release produces no pulse.
- Latency: from the first clk edge that samples btn_n[i]=0, a held press drives the pulse high after exactly DEBOUNCE_CYC+3 edges. The pulse lasts exactly 1 cycle.
- Glitch rejection: any input excursion shorter than DEBOUNCE_CYC synchronised cycles produces no level change and no pulse.
- TEST channel (bit 5): never emits on a short press.
  - hold_cnt counts while db[5]=1 and clears when db[5]=0.
  - When hold_cnt reaches HOLD_CYC-1 and hold_fired=0, raw test pulse = 1 for one cycle and hold_fired <= 1.
  - hold_cnt saturates.
  - hold_fired clears only when db[5] returns to 0, giving one pulse per hold with no auto-repeat.
- Priority: output pulses are registered. When several raw pulses coincide, only the lowest index is output: feeding > light_out > echo_sig > healing > change_state > test. The losers are dropped, not queued.
- btn_level = db, and is not priority-filtered.
- Reset mid-operation: all in-flight counts are discarded.
  - A button still held when rst falls is treated as a new press.
  - Its pulse follows the full latency rule, counted from the first post-reset edge.
- No output may be X after the first reset edge.

Decomposition:
- Package button_pkg:
  - Index constants BTN_FEED=0, BTN_LIGHT=1, BTN_ECHO=2, BTN_HEAL=3, BTN_CHANGE=4, BTN_TEST=5.
  - NUM_BTN=6.
  - Default DEBOUNCE_CYC and HOLD_CYC.
- Sub-module btn_debounce: one channel of synchroniser, debounce counter and db_d. It outputs level and rise and is instantiated NUM_BTN times.
- The top level holds the hold logic and the priority register.

Test Plan (DEBOUNCE_CYC=4, HOLD_CYC=20):
- Press btn_n[0] low and hold 30 cycles -> feeding=1 for exactly 1 cycle, 7 edges after the first low sample; btn_level[0]=1; no other pulse.
- Pulse btn_n[2] low for 3 cycles, then high -> no echo_sig pulse; btn_level[2] stays 0.
- Bounce btn_n[3] 0/1/0/1 every cycle for 10 cycles, then hold low -> exactly one healing pulse, 7 edges after the final stable low; release with bounce -> no pulse.
- Press btn_n[5] for 10 cycles, then release -> test stays 0. Hold for 60 cycles -> exactly one test pulse at hold_cnt=19, none after.
- Drive btn_n[1] and btn_n[4] low on the same edge -> light_out=1 only; change_state stays 0 throughout.
- Hold btn_n[0] low, assert rst for 2 cycles mid-debounce with the button still held -> outputs 0 during reset; one feeding pulse 7 edges after rst deasserts.
